// File: rtl/mem_bus_initiator_if.sv
// Memory / memory-mapped IO bus between the CPU-side initiator and its responders.
// The initiator drives strobes, address, lane enables and store data; a responder returns ack and read data.
interface mem_bus_initiator_if;
   logic        write_mem;
   logic        read_mem;
   logic [31:0] data_address;
   logic [31:0] data_to_write;
   logic [3:0]  byte_en;
   logic        bus_ack;
   logic [31:0] data_read;

   modport master (
      output write_mem, read_mem, data_address, data_to_write, byte_en,
      input  bus_ack, data_read
   );

   modport slave (
      input  write_mem, read_mem, data_address, data_to_write, byte_en,
      output bus_ack, data_read
   );
endinterface

// File: rtl/mem_bus_initiator.sv
// CPU-side load/store initiator: turns one core request into a held bus transaction,
// lane-aligns store data, extends load data and aborts with an error on misalignment or timeout.
module mem_bus_initiator #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [31:0]           req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  req_ready,
   output logic                  busy,
   mem_bus_initiator_if.master   bus,
   output logic                  rsp_valid,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   // A zero TIMEOUT_CYCLES still needs a one-bit counter to keep the vector legal.
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             write_q;
   logic             unsigned_q;
   logic [1:0]       size_q;
   logic [1:0]       offset_q;
   logic [31:0]      address_q;
   logic [31:0]      wdata_q;
   logic [3:0]       byte_en_q;
   logic [31:0]      rdata_q;
   logic             err_q;

   logic accept;
   logic misaligned;
   logic timeout_hit;
   logic ack_in_req;

   function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] offset);
      logic [3:0] be;
      case (size)
         2'd0:    be = 4'b0001 << offset;
         2'd1:    be = 4'b0011 << offset;
         2'd2:    be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] replicate_store(input logic [1:0] size, input logic [31:0] wdata);
      logic [31:0] data;
      case (size)
         2'd0:    data = {4{wdata[7:0]}};
         2'd1:    data = {2{wdata[15:0]}};
         default: data = wdata;
      endcase
      return data;
   endfunction

   function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] offset,
                                               input logic [1:0] size, input logic uns);
      logic [31:0] lane;
      logic [31:0] result;
      lane = word >> {offset, 3'b000};
      case (size)
         2'd0:    result = uns ? {24'd0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
         2'd1:    result = uns ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
         default: result = word;
      endcase
      return result;
   endfunction

   assign accept      = req_valid && (state_q == IDLE);
   assign misaligned  = (req_size == 2'd3) ||
                        ((req_size == 2'd1) && req_addr[0]) ||
                        ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
   assign ack_in_req  = (state_q == REQ) && bus.bus_ack;
   // Ack in the last allowed cycle takes priority over the timeout.
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == REQ) && !bus.bus_ack && (cnt_q == CNT_LAST);

   // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_d           = state_q;
      req_ready         = 1'b0;
      busy              = 1'b1;
      rsp_valid         = 1'b0;
      bus.write_mem     = 1'b0;
      bus.read_mem      = 1'b0;
      bus.data_address  = address_q;
      bus.data_to_write = wdata_q;
      bus.byte_en       = byte_en_q;
      rsp_rdata         = rdata_q;
      rsp_err           = err_q;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (accept) state_d = misaligned ? RESP : REQ;
         end
         REQ: begin
            bus.write_mem = write_q;
            bus.read_mem  = !write_q;
            if (bus.bus_ack || timeout_hit) state_d = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q      <= '0;
         write_q    <= 1'b0;
         unsigned_q <= 1'b0;
         size_q     <= 2'd0;
         offset_q   <= 2'd0;
         address_q  <= '0;
         wdata_q    <= '0;
         byte_en_q  <= '0;
      end else if (accept) begin
         cnt_q      <= '0;
         write_q    <= req_write;
         unsigned_q <= req_unsigned;
         size_q     <= req_size;
         offset_q   <= req_addr[1:0];
         address_q  <= {req_addr[31:2], 2'b00};
         wdata_q    <= replicate_store(req_size, req_wdata);
         byte_en_q  <= lane_enables(req_size, req_addr[1:0]);
      end else if ((state_q == REQ) && !bus.bus_ack) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // Response fields are loaded on the way into RESP and cleared on the way out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (accept && misaligned) begin
         rdata_q <= '0;
         err_q   <= 1'b1;
      end else if (ack_in_req) begin
         rdata_q <= write_q ? 32'd0 : extend_load(bus.data_read, offset_q, size_q, unsigned_q);
         err_q   <= 1'b0;
      end else if (timeout_hit) begin
         rdata_q <= '0;
         err_q   <= 1'b1;
      end else if (state_q == RESP) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end
   end

endmodule

// File: doc/mem_bus_initiator.md
Name: mem_bus_initiator

Overview:
- CPU-side initiator for the data memory / memory-mapped IO bus: turns one load/store request from the core into a held read_mem/write_mem transaction.
- Aligns and byte-enables store data, waits for a responder ack, then returns extended load data, with a timeout.
- Sits between the execute/memory stage and the data memory plus IO peripheral responders; the core stalls on busy.

Parameters:
- TIMEOUT_CYCLES, 16, cycles in REQ without bus_ack before aborting with error; 0 disables timeout.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  core presents a request
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  0 = byte, 1 = half, 2 = word; 3 treated as misaligned
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- req_ready  output  1  high only in IDLE; request accepted on req_valid && req_ready
- busy  output  1  high in any state other than IDLE; core stall
- write_mem  output  1  bus write strobe
- read_mem  output  1  bus read strobe
- data_address  output  32  word-aligned address, addr[1:0] forced 0
- data_to_write  output  32  store data replicated to all lanes
- byte_en  output  4  active lanes
- bus_ack  input  1  responder completes the transaction
- data_read  input  32  read data, valid with bus_ack
- rsp_valid  output  1  one-cycle completion pulse
- rsp_rdata  output  32  extended load data; 0 for stores and errors
- rsp_err  output  1  valid with rsp_valid; misaligned or timeout

Behaviour:
- States: IDLE, REQ, RESP.
- Reset (asynchronous, takes effect immediately even mid-transaction): state IDLE; write_mem, read_mem, rsp_valid and rsp_err 0; data_address, data_to_write, byte_en, rsp_rdata 0; timeout counter 0.
- IDLE, on accept: latch all request fields.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0, or size 3): go to RESP with err=1. No bus strobe is ever asserted.
  - Otherwise: go to REQ.
- REQ, strobes:
  - Exactly one of write_mem/read_mem is high every REQ cycle. Address, data and byte_en are held stable from the first REQ cycle until exit.
- REQ, byte_en: byte = 0001<<addr[1:0]; half = 0011<<addr[1:0]; word = 1111.
- REQ, store data: byte replicated x4; half replicated x2; word as-is.
- REQ, bus_ack sampled at each posedge:
  - An ack in the first REQ cycle is valid.
  - On ack: capture data_read, go to RESP with err=0.
- Timeout counter:
  - Width $clog2(TIMEOUT_CYCLES+1). Clears on entry to REQ and increments each REQ cycle without ack.
  - When it equals TIMEOUT_CYCLES-1 and ack is still absent: strobes drop at the edge, go to RESP with err=1.
  - Ack in that same cycle wins over timeout.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE.
  - Load: rsp_rdata = lane selected by addr[1:0], sign/zero-extended per size and req_unsigned.
  - Store or error: rsp_rdata=0.
- bus_ack outside REQ is ignored.
- Latency: accept at edge N; strobes high in cycle N+1; ack in cycle N+1 gives rsp_valid in cycle N+2.
  - Back-to-back: the next accept can happen in the cycle after RESP.
  - Misaligned: rsp_valid in cycle N+1.
- req_valid while busy: ignored; the core must hold the request.

Test Plan:
- Word load addr 0x0000_0010, ack on first REQ cycle with data_read 0xDEAD_BEEF -> read_mem 1 cycle, byte_en 1111, data_address 0x10; rsp_valid next cycle, rdata 0xDEADBEEF, err 0.
- Signed byte load addr 0x0000_0013, data_read 0x80FF_FF7F -> byte_en 1000; rdata 0xFFFF_FF80. Unsigned repeat -> 0x0000_0080.
- Half store 0x1234_ABCD to addr 0xFFFF_FFFE, ack after 3 cycles -> write_mem held 3 cycles, data_address 0xFFFF_FFFC, byte_en 1100, data_to_write 0xABCD_ABCD; rsp_valid with rdata 0, err 0.
- Word load addr 0x0000_0006 -> no strobe ever; rsp_valid+err the cycle after accept; req_ready back the following cycle.
- No ack, TIMEOUT_CYCLES=16 -> read_mem high exactly 16 cycles, then rsp_valid with err 1. Ack arriving on the 16th cycle -> err 0 with data.
- rst asserted mid-REQ -> write_mem/read_mem drop without waiting for clk; state IDLE, req_ready 1 after release; a stale bus_ack after release produces no rsp_valid.
